// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter that lets NUM_REQ producers share one FIFO write port.
//   A winner holds the grant for up to BURST accepted beats. The grant is
//   dropped early if the winner deasserts valid. Every grant is followed by
//   exactly one IDLE arbitration cycle.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous reset, active low
//   req_valid      : [NUM_REQ]            producer i presents a beat
//   req_data       : [NUM_REQ*DATA_WIDTH] producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      : [NUM_REQ]            producer i beat accepted this cycle
//   fifo_wr_en     : FIFO write enable
//   fifo_data_in   : [DATA_WIDTH] FIFO write data (data of grant_id holder)
//   fifo_full      : FIFO full flag
//   grant_valid    : a producer currently holds the grant
//   grant_id       : [$clog2(NUM_REQ)] current or most recent grant holder
// -----------------------------------------------------------------------------

// Per-producer slice: decodes whether this lane owns grant_id, masks its data
// onto the shared OR-bus and produces its ready bit.
module fifo_wr_arbiter_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int GID_W      = 2,
   parameter int LANE       = 0
) (
   input  logic [GID_W-1:0]      grant_id_i,
   input  logic                  accept_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  sel_o,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] data_o
);
   assign sel_o   = (grant_id_i == GID_W'(LANE));
   assign ready_o = sel_o & accept_i;
   assign data_o  = sel_o ? data_i : '0;
endmodule

module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST      = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   output logic                          grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
   localparam int GID_W = $clog2(NUM_REQ);
   localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e                  state_q, state_d;
   logic [GID_W-1:0]        grant_id_q, grant_id_d;
   logic [GID_W-1:0]        last_grant_q, last_grant_d;
   logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;

   logic [NUM_REQ-1:0]                 sel;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
   logic                               cur_valid;
   logic                               accept;
   logic [GID_W-1:0]                   winner;
   logic                               found;
   int                                 idx;

   // ---------------------------------------------------------------- lanes
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      fifo_wr_arbiter_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .GID_W      (GID_W),
         .LANE       (i)
      ) u_lane (
         .grant_id_i (grant_id_q),
         .accept_i   (accept),
         .data_i     (req_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .sel_o      (sel[i]),
         .ready_o    (req_ready[i]),
         .data_o     (lane_data[i])
      );
   end

   // Lanes drive zero unless selected, so the data mux is a plain OR.
   always_comb begin
      fifo_data_in = '0;
      for (int i = 0; i < NUM_REQ; i++) fifo_data_in |= lane_data[i];
   end

   assign cur_valid   = |(req_valid & sel);
   assign accept      = (state_q == GRANT) && cur_valid && !fifo_full;
   assign fifo_wr_en  = accept;
   assign grant_valid = (state_q == GRANT);
   assign grant_id    = grant_id_q;

   // ---------------------------------------------------------- round robin
   // Search starts one past the last winner and wraps; k = NUM_REQ revisits
   // the last winner itself so a lone requester can be regranted.
   always_comb begin
      winner = last_grant_q;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_grant_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = GID_W'(idx);
         end
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d      = GRANT;
               grant_id_d   = winner;
               last_grant_d = winner;
               beat_cnt_d   = '0;
            end
         end
         GRANT: begin
            if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
            // A full FIFO with valid held just stalls; only a completed burst
            // or a dropped valid ends the grant.
            if (!cur_valid || (accept && beat_cnt_q == LAST_BEAT)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= GID_W'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural producers and a 16-deep FIFO model,
// expected (grant_id, data) beats queued per scenario and compared on write,
// then compared again on FIFO read-back.
module tb_fifo_wr_arbiter;
   localparam int NR = 4, DW = 8, BURST = 4, DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     req_ready;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_data_in;
   logic              fifo_full = 1'b0;
   logic              grant_valid;
   logic [1:0]        grant_id;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST(BURST)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .fifo_full    (fifo_full),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [1:0] gid; logic [7:0] data; } beat_t;

   beat_t      exp_q[$];
   logic [7:0] rb_q[$];
   logic [7:0] fifo_q[$];
   logic [7:0] src[NR][$];

   int  nchk = 0, nerr = 0, nwr = 0, rd_cnt = 0, beats = 0;
   bit  drain = 1'b1;
   logic [NR-1:0] rdy_s = '0;
   logic          wr_s = 1'b0;
   logic [7:0]    dat_s = '0;
   logic          gv_p = 1'b0, wrlast_p = 1'b0, idle_pend_p = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic expect_beat(input int g, input logic [7:0] d);
      beat_t e;
      e.gid  = 2'(g);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Producers + FIFO model; advances #1 after each rising edge using values
   // sampled on the preceding falling edge.
   always @(posedge clk) begin
      logic [7:0] d;
      #1;
      for (int i = 0; i < NR; i++)
         if (rdy_s[i]) begin
            if (src[i].size() > 0) src[i].delete(0);
            else chk("pop_empty", 1, 0);
         end
      if (wr_s) begin
         if (fifo_q.size() < DEPTH) fifo_q.push_back(dat_s);
         else chk("fifo_overflow", 1, 0);
      end
      if (fifo_q.size() > 0 && (drain || rd_cnt > 0)) begin
         d = fifo_q.pop_front();
         if (rd_cnt > 0) rd_cnt--;
         if (rb_q.size() > 0) chk("readback", d, rb_q.pop_front());
         else chk("readback_extra", 1, 0);
      end
      for (int i = 0; i < NR; i++) begin
         req_valid[i]           = (src[i].size() > 0);
         req_data[i*DW +: DW]   = (src[i].size() > 0) ? src[i][0] : 8'h00;
      end
      fifo_full = (fifo_q.size() >= DEPTH);
   end

   // Monitor: protocol rules and write-side scoreboard.
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         rdy_s = '0; wr_s = 1'b0; beats = 0;
         gv_p = 1'b0; wrlast_p = 1'b0; idle_pend_p = 1'b0;
      end else begin
         rdy_s = req_ready; wr_s = fifo_wr_en; dat_s = fifo_data_in;
         if (idle_pend_p) chk("arb_latency", grant_valid, 1);
         if (wrlast_p)    chk("release_after_burst", grant_valid, 0);
         if (grant_valid && !gv_p) beats = 0;
         if (grant_valid && req_valid[grant_id] && !fifo_full) chk("accept", fifo_wr_en, 1);
         chk("ready_vec", req_ready, fifo_wr_en ? (NR'(1) << grant_id) : NR'(0));
         if (fifo_wr_en) begin
            nwr++; beats++;
            chk("wr_when_full", fifo_full, 0);
            chk("wr_granted", grant_valid, 1);
            chk("burst_len", 32'(beats <= BURST), 1);
            if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("wr_gid", grant_id, e.gid);
               chk("wr_data", fifo_data_in, e.data);
               rb_q.push_back(e.data);
            end
         end
         wrlast_p    = fifo_wr_en && (beats == BURST);
         idle_pend_p = !grant_valid && (req_valid != '0);
         gv_p        = grant_valid;
      end
   end

   task automatic wait_drained(input string tag, input int budget);
      int n = 0;
      while (n < budget && !(exp_q.size() == 0 && rb_q.size() == 0 && fifo_q.size() == 0 &&
             src[0].size() == 0 && src[1].size() == 0 && src[2].size() == 0 &&
             src[3].size() == 0 && !grant_valid)) begin
         @(negedge clk); #1; n++;
      end
      if (n >= budget) begin
         chk({"timeout_", tag}, 0, 1);
         exp_q.delete(); rb_q.delete();
      end
   endtask

   initial begin
      int base, n;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_gv", grant_valid, 0);
      chk("rst_wr", fifo_wr_en, 0);
      chk("rst_rdy", req_ready, 0);
      chk("rst_gid", grant_id, 0);

      // All four producers busy: 0,1,2,3,0 with 4 beats each.
      for (int p = 0; p < NR; p++) for (int k = 0; k < 4; k++) src[p].push_back(8'h10 + 8'(p));
      for (int k = 0; k < 4; k++) src[0].push_back(8'h10);
      for (int p = 0; p < NR; p++) for (int k = 0; k < 4; k++) expect_beat(p, 8'h10 + 8'(p));
      for (int k = 0; k < 4; k++) expect_beat(0, 8'h10);
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("first_grant_gv", grant_valid, 1);
      chk("first_grant_id", grant_id, 0);
      wait_drained("rr4", 300);

      // Producer 1 drops valid after 2 beats while producer 3 waits.
      @(negedge clk);
      src[1].push_back(8'h31); src[1].push_back(8'h32); src[3].push_back(8'h33);
      expect_beat(1, 8'h31); expect_beat(1, 8'h32); expect_beat(3, 8'h33);
      wait_drained("early_drop", 100);

      // Lone producer 2, 6 beats: burst of 4, bubble, burst of 2.
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         src[2].push_back(8'hA0 + 8'(k));
         expect_beat(2, 8'hA0 + 8'(k));
      end
      wait_drained("lone", 100);

      // Fill FIFO, then producer 0 stalls on full; one read frees one write.
      @(negedge clk);
      drain = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         src[3].push_back(8'hC0 + 8'(k));
         expect_beat(3, 8'hC0 + 8'(k));
      end
      n = 0;
      while (n < 200 && fifo_q.size() < DEPTH) begin @(negedge clk); #1; n++; end
      chk("fifo_filled", fifo_q.size(), DEPTH);
      chk("full_flag", fifo_full, 1);
      src[0].push_back(8'hD0); src[0].push_back(8'hD1);
      expect_beat(0, 8'hD0); expect_beat(0, 8'hD1);
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("stall_wr", fifo_wr_en, 0);
         chk("stall_gv", grant_valid, 1);
         chk("stall_gid", grant_id, 0);
         @(negedge clk); #1;
      end
      base = nwr;
      rd_cnt = 1;
      repeat (4) @(negedge clk);
      #1;
      chk("one_read_one_write", nwr - base, 1);
      chk("stall_hold_gv", grant_valid, 1);
      drain = 1'b1;
      wait_drained("full", 200);

      // Reset mid-burst after 2 beats of producer 1.
      @(negedge clk);
      for (int k = 0; k < 4; k++) src[1].push_back(8'hE0 + 8'(k));
      expect_beat(1, 8'hE0); expect_beat(1, 8'hE1);
      base = nwr; n = 0;
      while (n < 50 && nwr < base + 2) begin @(negedge clk); #1; n++; end
      chk("mid_burst_beats", nwr - base, 2);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_gv", grant_valid, 0);
      chk("rst_mid_wr", fifo_wr_en, 0);
      chk("rst_mid_rdy", req_ready, 0);
      chk("rst_mid_gid", grant_id, 0);
      @(negedge clk);
      src[0].push_back(8'hF0);
      expect_beat(0, 8'hF0); expect_beat(1, 8'hE2); expect_beat(1, 8'hE3);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_gv", grant_valid, 1);
      chk("post_rst_gid", grant_id, 0);
      wait_drained("reset", 200);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
